// File: rtl/arb_pkg.sv
// Shared arbiter definitions: mode codes, FSM state encoding and
// a one-hot to binary helper reused by the arbiter family.
package arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Supports up to 32 requesters; returns 0 for an all-zero vector.
    function automatic int onehot2bin(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select: first set request scanning circularly
// from ptr (round robin) or from index 0 (fixed priority).
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    win,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    int start;
    int idx;

    always_comb begin
        win   = '0;
        idx   = 0;
        start = mode ? int'(ptr) : 0;
        for (int i = 0; i < N; i++) begin
            idx = (start + i) % N;
            if (req[idx] && (win == '0)) win[idx] = 1'b1;
        end
    end

    assign any    = |req;
    assign win_id = ID_W'(onehot2bin(32'(win)));

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master bus arbiter: fixed-priority or round-robin selection with
// an optional burst limit that preempts a long-running owner.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int MODE      = 1,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id
);

    localparam int CNT_W =
        (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_MASTERS - 1);
    localparam bit RR = (MODE == MODE_RR);
    localparam bit CAN_PREEMPT = RR && (MAX_BURST != 0);

    arb_state_t           state;
    logic [ID_W-1:0]      ptr;
    logic [CNT_W-1:0]     burst_cnt;

    logic [N_MASTERS-1:0] masked_req;
    logic [N_MASTERS-1:0] all_win;
    logic [N_MASTERS-1:0] mask_win;
    logic [ID_W-1:0]      all_id;
    logic [ID_W-1:0]      mask_id;
    logic                 all_any;
    logic                 mask_any;
    logic                 own_req;
    logic                 preempt;

    logic                 take;
    logic [N_MASTERS-1:0] take_win;
    logic [ID_W-1:0]      take_id;

    assign masked_req = req & ~grant;
    assign own_req    = |(req & grant);
    assign preempt    = CAN_PREEMPT && (burst_cnt == CNT_MAX)
                        && mask_any;

    arb_rr_pick #(.N(N_MASTERS), .ID_W(ID_W)) u_pick_all (
        .req    (req),
        .ptr    (ptr),
        .mode   (RR),
        .win    (all_win),
        .win_id (all_id),
        .any    (all_any)
    );

    arb_rr_pick #(.N(N_MASTERS), .ID_W(ID_W)) u_pick_mask (
        .req    (masked_req),
        .ptr    (ptr),
        .mode   (RR),
        .win    (mask_win),
        .win_id (mask_id),
        .any    (mask_any)
    );

    function automatic logic [ID_W-1:0] ptr_after(
        input logic [ID_W-1:0] k
    );
        return (k == ID_LAST) ? '0 : k + 1'b1;
    endfunction

    // Owner change decision; a release with no requester yields an
    // all-zero take_win, which drops the FSM back to idle.
    always_comb begin
        take     = 1'b0;
        take_win = all_win;
        take_id  = all_id;
        if (state == ST_IDLE) begin
            take = all_any;
        end else if (!own_req) begin
            take = 1'b1;
        end else if (preempt) begin
            take     = 1'b1;
            take_win = mask_win;
            take_id  = mask_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            burst_cnt   <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else if (take) begin
            grant       <= take_win;
            grant_valid <= |take_win;
            grant_id    <= take_id;
            burst_cnt   <= '0;
            state       <= (|take_win) ? ST_OWNED : ST_IDLE;
            if (RR && (|take_win)) ptr <= ptr_after(take_id);
        end else if (state == ST_OWNED && burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule
